// File: rtl/ex_mem_if.sv
// EX -> MEM stage bus: pipeline controls and EX-side fields in, MEM-side
// registered fields and forwarding tap out.
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_result;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_rt_data;
    logic [REG_W-1:0]  ex_dest_reg;
    logic [5:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_branch_target;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_rt_data;
    logic [REG_W-1:0]  mem_dest_reg;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              fwd_en;
    logic [REG_W-1:0]  fwd_dest;
    logic [DATA_W-1:0] fwd_data;

    // upstream side (EX stage / hazard unit)
    modport master (
        output stall, flush, ex_valid, ex_alu_result, ex_zero, ex_rt_data,
               ex_dest_reg, ex_ctrl, ex_branch_target,
        input  mem_valid, mem_alu_result, mem_rt_data, mem_dest_reg,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               branch_taken, branch_target, fwd_en, fwd_dest, fwd_data
    );

    // the pipeline register itself
    modport slave (
        input  stall, flush, ex_valid, ex_alu_result, ex_zero, ex_rt_data,
               ex_dest_reg, ex_ctrl, ex_branch_target,
        output mem_valid, mem_alu_result, mem_rt_data, mem_dest_reg,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               branch_taken, branch_target, fwd_en, fwd_dest, fwd_data
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and travelling control,
// resolves conditional branches from the sampled zero flag, and exposes
// a forwarding tap back to the EX operand muxes.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_mem_if.slave  bus
);
    // control registers (cleared by flush)
    logic v_q, rw_q, mr_q, mw_q, m2r_q, bt_q;
    // data registers (held by flush)
    logic [DATA_W-1:0] alu_q, rt_q, tgt_q;
    logic [REG_W-1:0]  dest_q;

    logic beq, bne, rw_d, mr_d, mw_d, m2r_d, bt_d;

    // Decode incoming control; everything is gated by ex_valid so an
    // invalid EX slot loads as a bubble. Both branch bits set is treated
    // as an unconditional taken branch.
    always_comb begin
        beq   = bus.ex_ctrl[1];
        bne   = bus.ex_ctrl[0];
        rw_d  = bus.ex_valid & bus.ex_ctrl[5] & (bus.ex_dest_reg != '0);
        mw_d  = bus.ex_valid & bus.ex_ctrl[3];
        mr_d  = bus.ex_valid & bus.ex_ctrl[4] & ~bus.ex_ctrl[3];
        m2r_d = bus.ex_valid & bus.ex_ctrl[2];
        bt_d  = bus.ex_valid & ((beq & bne) | (beq & bus.ex_zero) | (bne & ~bus.ex_zero));
    end

    // Control registers: flush beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0; rw_q <= 1'b0; mr_q <= 1'b0;
            mw_q <= 1'b0; m2r_q <= 1'b0; bt_q <= 1'b0;
        end else if (bus.flush) begin
            v_q <= 1'b0; rw_q <= 1'b0; mr_q <= 1'b0;
            mw_q <= 1'b0; m2r_q <= 1'b0; bt_q <= 1'b0;
        end else if (!bus.stall) begin
            v_q   <= bus.ex_valid;
            rw_q  <= rw_d;
            mr_q  <= mr_d;
            mw_q  <= mw_d;
            m2r_q <= m2r_d;
            bt_q  <= bt_d;
        end
    end

    // Data registers: load whenever the stage advances; a flushed slot is
    // invalid anyway, so its data is simply left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q  <= '0;
            rt_q   <= '0;
            tgt_q  <= '0;
            dest_q <= '0;
        end else if (!bus.flush && !bus.stall) begin
            alu_q  <= bus.ex_alu_result;
            rt_q   <= bus.ex_rt_data;
            tgt_q  <= bus.ex_branch_target;
            dest_q <= bus.ex_dest_reg;
        end
    end

    assign bus.mem_valid      = v_q;
    assign bus.mem_alu_result = alu_q;
    assign bus.mem_rt_data    = rt_q;
    assign bus.mem_dest_reg   = dest_q;
    assign bus.mem_reg_write  = rw_q;
    assign bus.mem_mem_read   = mr_q;
    assign bus.mem_mem_write  = mw_q;
    assign bus.mem_mem_to_reg = m2r_q;
    assign bus.branch_taken   = bt_q;
    assign bus.branch_target  = tgt_q;

    // Loads have no value yet in this stage, so they never forward.
    assign bus.fwd_en   = v_q & rw_q & ~m2r_q;
    assign bus.fwd_dest = dest_q;
    assign bus.fwd_data = alu_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed steps plus a randomized stream, checked
// against an instruction-level reference model of the stage contents.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_if #(.DATA_W(32), .REG_W(5)) bus ();
    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        rw, mr, mw, m2r, bt;
        logic [31:0] tgt;
    } st_t;

    localparam logic [5:0] C_RW   = 6'b100000;
    localparam logic [5:0] C_MR   = 6'b010000;
    localparam logic [5:0] C_MW   = 6'b001000;
    localparam logic [5:0] C_M2R  = 6'b000100;
    localparam logic [5:0] C_BEQ  = 6'b000010;
    localparam logic [5:0] C_BNE  = 6'b000001;

    st_t exp;
    int checks = 0;
    int errors = 0;

    function automatic st_t empty_st();
        st_t s;
        s.valid = 0; s.alu = 0; s.rt = 0; s.dest = 0;
        s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0; s.bt = 0; s.tgt = 0;
        return s;
    endfunction

    // What the stage should hold after the next edge, from the instruction
    // presented in EX and the stall/flush requests.
    function automatic st_t model_next(st_t cur);
        st_t n = cur;
        bit is_beq, is_bne, taken;
        if (bus.flush) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.bt = 0;
        end else if (!bus.stall) begin
            n.alu  = bus.ex_alu_result;
            n.rt   = bus.ex_rt_data;
            n.tgt  = bus.ex_branch_target;
            n.dest = bus.ex_dest_reg;
            n.valid = bus.ex_valid;
            is_beq = bus.ex_ctrl[1];
            is_bne = bus.ex_ctrl[0];
            if (is_beq && is_bne)  taken = 1;
            else if (is_beq)       taken = bus.ex_zero;
            else if (is_bne)       taken = !bus.ex_zero;
            else                   taken = 0;
            if (!bus.ex_valid) begin
                n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.bt = 0;
            end else begin
                n.rw  = bus.ex_ctrl[5] && (bus.ex_dest_reg != 0);
                n.mw  = bus.ex_ctrl[3];
                n.mr  = bus.ex_ctrl[4] && !bus.ex_ctrl[3];
                n.m2r = bus.ex_ctrl[2];
                n.bt  = taken;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ":valid"}, 32'(bus.mem_valid),      32'(exp.valid));
        chk({step, ":alu"},   bus.mem_alu_result,      exp.alu);
        chk({step, ":rt"},    bus.mem_rt_data,         exp.rt);
        chk({step, ":dest"},  32'(bus.mem_dest_reg),   32'(exp.dest));
        chk({step, ":rw"},    32'(bus.mem_reg_write),  32'(exp.rw));
        chk({step, ":mr"},    32'(bus.mem_mem_read),   32'(exp.mr));
        chk({step, ":mw"},    32'(bus.mem_mem_write),  32'(exp.mw));
        chk({step, ":m2r"},   32'(bus.mem_mem_to_reg), 32'(exp.m2r));
        chk({step, ":bt"},    32'(bus.branch_taken),   32'(exp.bt));
        chk({step, ":tgt"},   bus.branch_target,       exp.tgt);
        chk({step, ":fwd_en"},   32'(bus.fwd_en),  32'(exp.valid & exp.rw & ~exp.m2r));
        chk({step, ":fwd_dest"}, 32'(bus.fwd_dest), 32'(exp.dest));
        chk({step, ":fwd_data"}, bus.fwd_data,      exp.alu);
    endtask

    task automatic set_in(input logic v, input logic [31:0] alu, input logic z,
                          input logic [31:0] rt, input logic [4:0] dest,
                          input logic [5:0] ctrl, input logic [31:0] tgt,
                          input logic st, input logic fl);
        bus.ex_valid = v; bus.ex_alu_result = alu; bus.ex_zero = z;
        bus.ex_rt_data = rt; bus.ex_dest_reg = dest; bus.ex_ctrl = ctrl;
        bus.ex_branch_target = tgt; bus.stall = st; bus.flush = fl;
    endtask

    task automatic set_rand(input logic st, input logic fl);
        logic [4:0] d;
        d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        set_in(1'($urandom_range(0, 5) != 0), $urandom, 1'($urandom), $urandom,
               d, 6'($urandom), $urandom, st, fl);
    endtask

    // One clock: predict, take the edge, compare just after it, return at negedge.
    task automatic cycle(input string step);
        st_t nxt;
        nxt = model_next(exp);
        @(posedge clk);
        exp = nxt;
        #1 check_all(step);
        @(negedge clk);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp = empty_st();
        // reset state
        @(negedge clk); @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // load a valid instruction, then assert reset mid-cycle
        set_in(1, 32'h0000_0010, 0, 32'hCAFE_0001, 5'd5, C_RW, 32'h100, 0, 0);
        cycle("preload");
        chk("preload_alu", bus.mem_alu_result, 32'h10);
        rst_n = 1'b0;
        exp = empty_st();
        #1 check_all("async_reset");
        #1 rst_n = 1'b1;
        @(negedge clk);

        // first edge after release loads normally
        set_in(1, 32'h0000_0010, 0, 32'h1234_5678, 5'd5, C_RW, 32'h0, 0, 0);
        cycle("load");
        chk("load_fwd_en",   32'(bus.fwd_en), 32'd1);
        chk("load_fwd_dest", 32'(bus.fwd_dest), 32'd5);
        chk("load_fwd_data", bus.fwd_data, 32'h10);

        // branch resolution, both polarities
        set_in(1, 32'h0, 1, 32'h0, 5'd0, C_BEQ, 32'h0000_0040, 0, 0);
        cycle("beq_taken");
        chk("beq_taken_bt", 32'(bus.branch_taken), 32'd1);
        chk("beq_taken_tgt", bus.branch_target, 32'h40);
        set_in(1, 32'h1, 0, 32'h0, 5'd0, C_BEQ, 32'h0000_0040, 0, 0);
        cycle("beq_not");
        chk("beq_not_bt", 32'(bus.branch_taken), 32'd0);
        set_in(1, 32'h1, 0, 32'h0, 5'd0, C_BNE, 32'h0000_0080, 0, 0);
        cycle("bne_taken");
        chk("bne_taken_bt", 32'(bus.branch_taken), 32'd1);
        set_in(1, 32'h0, 1, 32'h0, 5'd0, C_BNE, 32'h0000_0080, 0, 0);
        cycle("bne_not");
        set_in(1, 32'h0, 0, 32'h0, 5'd0, C_BEQ | C_BNE, 32'h0000_00C0, 0, 0);
        cycle("both_br");
        chk("both_br_bt", 32'(bus.branch_taken), 32'd1);
        // invalid slot with branch bits does not resolve taken
        set_in(0, 32'h0, 1, 32'h0, 5'd3, C_BEQ | C_RW, 32'h0000_0100, 0, 0);
        cycle("bubble_br");

        // valid instruction, then 3 stalled cycles with changing inputs
        set_in(1, 32'hAAAA_5555, 1, 32'h0F0F_0F0F, 5'd9, C_RW | C_BEQ, 32'h200, 0, 0);
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            set_rand(1, 0);
            cycle("stall");
        end
        chk("stall_hold_alu", bus.mem_alu_result, 32'hAAAA_5555);
        // stall and flush together: flush wins
        set_rand(1, 1);
        cycle("stall_flush");
        chk("flush_valid", 32'(bus.mem_valid), 32'd0);
        chk("flush_bt", 32'(bus.branch_taken), 32'd0);

        // branch taken, then flush in the following cycle clears it
        set_in(1, 32'h0, 1, 32'h0, 5'd0, C_BEQ, 32'h300, 0, 0);
        cycle("bt_before_flush");
        set_rand(0, 1);
        cycle("flush_after_bt");

        // r0 write suppression and store-beats-load
        set_in(1, 32'h55, 0, 32'h0, 5'd0, C_RW, 32'h0, 0, 0);
        cycle("r0");
        chk("r0_fwd_en", 32'(bus.fwd_en), 32'd0);
        set_in(1, 32'h1000, 0, 32'hBEEF, 5'd7, C_MR | C_MW, 32'h0, 0, 0);
        cycle("rd_wr");
        chk("rd_wr_mw", 32'(bus.mem_mem_write), 32'd1);
        chk("rd_wr_mr", 32'(bus.mem_mem_read), 32'd0);

        // back-to-back stream of 8, one of them a load
        for (int i = 0; i < 8; i++) begin
            if (i == 3) set_in(1, $urandom, 0, $urandom, 5'd12, C_RW | C_MR | C_M2R, $urandom, 0, 0);
            else        set_in(1, $urandom, 1'($urandom), $urandom, 5'($urandom_range(1, 31)),
                               6'($urandom), $urandom, 0, 0);
            cycle("stream");
            if (i == 3) chk("stream_load_fwd_en", 32'(bus.fwd_en), 32'd0);
        end

        // randomized traffic with occasional stall/flush
        for (int i = 0; i < 300; i++) begin
            set_rand(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
